bsg_age_stamper: RTL and testbench

- Per-input request queueing stage that sits directly upstream of the age arbiter.
- Accepts valid/ready requests on inputs_p channels and tags each with an arrival timestamp from a shared counter.
- Presents each queue head to the arbiter as a request bit plus timestamp, and pops the head named by the returned grant.
- Keeps every live timestamp monotonic, so the arbiter's plain unsigned "<" compare stays correct across counter wrap.

---
 rtl/bsg_age_stamper_if.sv | 26 ++
 rtl/bsg_age_stamper.sv | 112 +++++++++++
 tb/tb_bsg_age_stamper.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_age_stamper_if.sv
// Request/arbiter-side bundle for bsg_age_stamper.
// master = upstream + arbiter driver, slave = stamper.
interface bsg_age_stamper_if #(
  parameter int inputs_p   = 2,
  parameter int ts_width_p = 8,
  parameter int width_p    = 32
);
  logic [inputs_p-1:0]                 v_i;
  logic [inputs_p-1:0][width_p-1:0]    data_i;
  logic [inputs_p-1:0]                 ready_o;
  logic [inputs_p-1:0]                 reqs_o;
  logic [inputs_p-1:0][ts_width_p-1:0] ts_o;
  logic [inputs_p-1:0]                 grants_i;
  logic                                v_o;
  logic [width_p-1:0]                  data_o;

  modport master (
    output v_i, data_i, grants_i,
    input  ready_o, reqs_o, ts_o, v_o, data_o
  );

  modport slave (
    input  v_i, data_i, grants_i,
    output ready_o, reqs_o, ts_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_age_stamper.sv
// Per-channel FIFOs that stamp arrivals for the age arbiter.
// Stamps stay monotonic: on counter saturation the block drains, then rebases.
module bsg_age_stamper #(
  parameter int inputs_p   = 2,
  parameter int ts_width_p = 8,
  parameter int width_p    = 32,
  parameter int els_p      = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  bsg_age_stamper_if.slave io
);
  localparam int lg_els_lp = $clog2(els_p);
  localparam int ent_w_lp  = width_p + ts_width_p;

  typedef enum logic {NORM, DRAIN} state_e;

  state_e                    state_r, state_n;
  logic [ts_width_p-1:0]     ts_r, ts_n;
  logic [lg_els_lp:0]        wptr_r [inputs_p];
  logic [lg_els_lp:0]        rptr_r [inputs_p];
  logic [ent_w_lp-1:0]       mem_r  [inputs_p][els_p];

  logic [inputs_p-1:0]       full, empty, enq, pop, ready;
  logic [inputs_p-1:0][width_p-1:0]    head_data;
  logic [inputs_p-1:0][ts_width_p-1:0] head_ts;
  logic                      grant_ok;

  for (genvar i = 0; i < inputs_p; i++) begin : g_ch
    logic [ent_w_lp-1:0] head;
    assign head = mem_r[i][rptr_r[i][lg_els_lp-1:0]];
    assign empty[i] = (wptr_r[i] == rptr_r[i]);
    assign full[i] =
      (wptr_r[i][lg_els_lp-1:0] == rptr_r[i][lg_els_lp-1:0])
      & (wptr_r[i][lg_els_lp] != rptr_r[i][lg_els_lp]);
    assign head_data[i] = head[ent_w_lp-1:ts_width_p];
    assign head_ts[i] = empty[i] ? '0 : head[ts_width_p-1:0];
  end

  // No bypass: a full queue refuses even while popping.
  assign ready = (reset_i || state_r != NORM) ? '0 : ~full;
  assign enq   = io.v_i & ready;

  assign grant_ok =
    ((io.grants_i & (io.grants_i - 1'b1)) == '0)
    && ((io.grants_i & empty) == '0);
  assign pop = grant_ok ? io.grants_i : '0;

  assign io.ready_o = ready;
  assign io.reqs_o  = ~empty;
  assign io.ts_o    = head_ts;
  assign io.v_o     = |pop;

  always_comb begin
    io.data_o = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (pop[i]) io.data_o = head_data[i];
    end
  end

  always_comb begin
    state_n = state_r;
    ts_n    = ts_r;
    unique case (state_r)
      NORM: begin
        if (|enq) begin
          if (&ts_r) state_n = DRAIN;
          else       ts_n = ts_r + 1'b1;
        end else if (&empty) begin
          ts_n = '0;
        end
      end
      DRAIN: begin
        if (&empty) begin
          state_n = NORM;
          ts_n    = '0;
        end
      end
      default: state_n = NORM;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= NORM;
      ts_r    <= '0;
      for (int i = 0; i < inputs_p; i++) begin
        wptr_r[i] <= '0;
        rptr_r[i] <= '0;
      end
    end else begin
      state_r <= state_n;
      ts_r    <= ts_n;
      for (int i = 0; i < inputs_p; i++) begin
        if (enq[i]) wptr_r[i] <= wptr_r[i] + 1'b1;
        if (pop[i]) rptr_r[i] <= rptr_r[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < inputs_p; i++) begin
      if (enq[i])
        mem_r[i][wptr_r[i][lg_els_lp-1:0]] <= {io.data_i[i], ts_r};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && !grant_ok)
      $warning("bsg_age_stamper: illegal grants_i %b", io.grants_i);
  end
endmodule

// File: tb/tb_bsg_age_stamper.sv
// Scoreboard bench for bsg_age_stamper.
// Queue-level reference model; payload monitor runs separately.
module tb_bsg_age_stamper;
  localparam int N  = 2;
  localparam int TW = 3;
  localparam int W  = 16;
  localparam int E  = 2;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [TW-1:0] ts;
  } ent_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  bsg_age_stamper_if #(.inputs_p(N), .ts_width_p(TW), .width_p(W)) io();

  bsg_age_stamper #(
    .inputs_p(N), .ts_width_p(TW), .width_p(W), .els_p(E)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .io(io)
  );

  int checks = 0;
  int errors = 0;

  ent_t         mq [N][$];
  logic [W-1:0] exp_q [$];
  int           m_ts;
  bit           m_drain;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ts = 0;
    m_drain = 0;
  endtask

  function automatic logic [N-1:0] oldest();
    int best = -1;
    logic [N-1:0] g = '0;
    for (int i = 0; i < N; i++)
      if (mq[i].size() > 0)
        if (best < 0 || mq[i][0].ts < mq[best][0].ts) best = i;
    if (best >= 0) g[best] = 1'b1;
    return g;
  endfunction

  function automatic logic [N-1:0] to_empty();
    logic [N-1:0] g = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mq[i].size() == 0) begin
        g = '0;
        g[i] = 1'b1;
      end
    return g;
  endfunction

  // gmode: 0 none, 1 oldest, 2 all-ones, 3 empty queue, 4 random, 5 ch0
  task automatic cycle(input logic [N-1:0] v, input int gmode);
    logic [N-1:0] g, exp_reqs, exp_rdy, menq;
    bit legal, all_empty;
    int r, gm;
    @(negedge clk);
    exp_reqs = '0;
    exp_rdy = '0;
    for (int i = 0; i < N; i++) begin
      exp_reqs[i] = mq[i].size() > 0;
      exp_rdy[i] = !m_drain && mq[i].size() < E;
    end
    check("reqs_o", 32'(io.reqs_o), 32'(exp_reqs));
    check("ready_o", 32'(io.ready_o), 32'(exp_rdy));
    for (int i = 0; i < N; i++)
      check($sformatf("ts_o[%0d]", i), 32'(io.ts_o[i]),
            mq[i].size() > 0 ? 32'(mq[i][0].ts) : 32'd0);

    gm = gmode;
    if (gm == 4) begin
      r = $urandom_range(0, 9);
      gm = (r == 0) ? 2 : (r == 1) ? 3 : (r < 4) ? 0 : 1;
    end
    case (gm)
      1: g = oldest();
      2: g = '1;
      3: g = to_empty();
      5: g = N'(1);
      default: g = '0;
    endcase

    io.v_i = v;
    for (int i = 0; i < N; i++) io.data_i[i] = W'($urandom);
    io.grants_i = g;

    legal = ((g & (g - 1'b1)) == '0);
    for (int i = 0; i < N; i++)
      if (g[i] && mq[i].size() == 0) legal = 0;
    all_empty = 1;
    for (int i = 0; i < N; i++)
      if (mq[i].size() > 0) all_empty = 0;
    for (int i = 0; i < N; i++) menq[i] = v[i] && exp_rdy[i];

    for (int i = 0; i < N; i++)
      if (legal && g[i]) begin
        exp_q.push_back(mq[i][0].d);
        void'(mq[i].pop_front());
      end
    for (int i = 0; i < N; i++)
      if (menq[i]) mq[i].push_back('{d: io.data_i[i], ts: TW'(m_ts)});

    if (!m_drain) begin
      if (menq != '0) begin
        if (m_ts == (1 << TW) - 1) m_drain = 1;
        else m_ts++;
      end else if (all_empty) begin
        m_ts = 0;
      end
    end else if (all_empty) begin
      m_ts = 0;
      m_drain = 0;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    io.v_i = '0;
    io.grants_i = '0;
    #3 reset_i = 1'b1;
    #1;
    check("reqs_o in reset", 32'(io.reqs_o), 32'd0);
    check("ready_o in reset", 32'(io.ready_o), 32'd0);
    check("ts_o in reset", 32'(io.ts_o), 32'd0);
    model_reset();
    @(negedge clk);
    #3 reset_i = 1'b0;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (io.v_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected v_o actual 1 required 0 data %0h",
                   io.data_o);
        end else begin
          e = exp_q.pop_front();
          if (io.data_o !== e) begin
            errors++;
            $display("FAIL data_o actual %0h required %0h", io.data_o, e);
          end
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missing v_o actual 0 required 1 data %0h", e);
      end
    end
  end

  initial begin : stim
    io.v_i = '0;
    io.data_i = '0;
    io.grants_i = '0;
    model_reset();
    #2;
    check("ready_o held in reset", 32'(io.ready_o), 32'd0);
    check("reqs_o held in reset", 32'(io.reqs_o), 32'd0);
    @(negedge clk);
    #3 reset_i = 1'b0;

    repeat (3) cycle('0, 0);

    cycle(2'b01, 0);
    cycle(2'b10, 0);
    cycle(2'b00, 0);
    cycle(2'b00, 1);
    cycle(2'b00, 1);
    cycle(2'b00, 0);

    repeat (3) cycle(2'b01, 0);
    cycle(2'b01, 5);
    cycle(2'b00, 0);
    repeat (3) cycle(2'b00, 1);

    repeat (14) cycle(2'b01, 1);
    repeat (4) cycle(2'b00, 1);
    cycle(2'b01, 0);
    cycle(2'b00, 1);
    cycle(2'b00, 0);

    repeat (5) cycle(2'b01, 1);
    cycle(2'b00, 1);
    cycle(2'b00, 0);
    cycle(2'b01, 0);
    cycle(2'b00, 1);

    cycle(2'b11, 0);
    cycle(2'b01, 0);
    cycle(2'b00, 2);
    cycle(2'b00, 1);
    cycle(2'b00, 1);
    cycle(2'b00, 3);
    cycle(2'b00, 1);
    cycle(2'b00, 0);

    cycle(2'b11, 0);
    cycle(2'b01, 0);
    async_reset();
    cycle(2'b01, 0);
    cycle(2'b00, 0);
    cycle(2'b00, 1);

    repeat (600) cycle(N'($urandom_range(0, 3)), 4);

    repeat (2) cycle('0, 0);
    @(negedge clk);
    #4;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
